rib_xbar: RTL and testbench
===========================

Name: rib_xbar

Overview:
- Parametrised successor to the fixed 3-master/4-slave RIB interconnect.
- Connects N_MASTERS bus masters (core, uart_debug, future DMA) to N_SLAVES memory-mapped slaves (rom, ram, uart, gpio, ...).
- Uses registered round-robin arbitration with an anti-starvation burst limit and per-master hold flags.
- Flags accesses to unmapped slave indices with an error pulse and captured address.

Parameters:
- N_MASTERS, 3, number of master ports (2..8)
- N_SLAVES, 4, number of slave ports (1..16)
- AW, 32, address width
- DW, 32, data width
- SEL_HI, 31, MSB of the slave-select field in the address
- SEL_W, 4, width of the slave-select field (addr[SEL_HI -: SEL_W])
- MAX_BURST, 16, max consecutive owned cycles while another master waits; 0 = unlimited

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- m_wr_req_i  in  N_MASTERS  per-master write bus request
- m_wr_en_i  in  N_MASTERS  per-master write strobe
- m_wr_addr_i  in  N_MASTERS*AW  packed write addresses, master i at [i*AW +: AW]
- m_wr_data_i  in  N_MASTERS*DW  packed write data
- m_rd_req_i  in  N_MASTERS  per-master read bus request
- m_rd_addr_i  in  N_MASTERS*AW  packed read addresses
- m_rd_data_o  out  N_MASTERS*DW  packed read data, owner only, others 0
- m_hold_o  out  N_MASTERS  stall flag to each master
- s_wr_en_o  out  N_SLAVES  per-slave write strobe
- s_wr_addr_o  out  N_SLAVES*AW  packed write address, offset field only (select bits zeroed)
- s_wr_data_o  out  N_SLAVES*DW  packed write data
- s_rd_addr_o  out  N_SLAVES*AW  packed read address, offset field only
- s_rd_data_i  in  N_SLAVES*DW  packed slave read data (combinational read)
- err_o  out  1  one-cycle pulse on an unmapped access
- err_addr_o  out  AW  address of the most recent unmapped access

Behaviour:
- Request per master: req[i] = m_wr_req_i[i] | m_rd_req_i[i].
- Reset (rst_n low at a posedge) values:
  - own_vld=0, gnt_q=0, rr_ptr=N_MASTERS-1 (master 0 wins first), burst_cnt=0, err_o=0, err_addr_o=0.
- States:
  - IDLE (own_vld=0): no routing; all s_*_o = 0.
  - OWNED (own_vld=1): gnt_q holds the one-hot owner.
- Arbitrate in a cycle when any of these holds:
  - IDLE; or
  - owner's req is low; or
  - burst limit hit: MAX_BURST!=0, burst_cnt==MAX_BURST-1 and another req pending.
- Arbitration result:
  - Round-robin search from rr_ptr+1 mod N_MASTERS over req.
  - Winner is registered at the posedge into gnt_q; rr_ptr <= winner; burst_cnt <= 0; own_vld=1.
  - No requester: own_vld <= 0, rr_ptr unchanged.
- Otherwise, while OWNED: burst_cnt increments, saturating at MAX_BURST-1.
- Latency:
  - Request to an idle bus: granted and routed from the next cycle (1 cycle of hold).
  - Handoff when the owner drops req with others waiting: zero-bubble; the new owner is routed the following cycle.
- Sole requester at burst expiry re-wins immediately; no stall.
- Hold: m_hold_o[i] = req[i] & ~(own_vld & gnt_q[i]), combinational.
- Routing while OWNED:
  - Owner write channel is decoded by wr_addr select field; owner read channel by rd_addr select field.
  - Read and write may target different slaves in the same cycle.
  - s_wr_en_o[sel] = owner m_wr_en_i & m_wr_req_i.
  - Owner m_rd_data_o = s_rd_data_i[rd_sel] when m_rd_req_i, else 0.
  - Non-selected slaves see all-zero inputs.
- Unmapped access (select value >= N_SLAVES) on an active channel:
  - Write is dropped; read data = 0.
  - err_o registered high for exactly one cycle per offending cycle.
  - err_addr_o <= offending address; a write wins if both channels are unmapped.
- Synchronous reset mid-transaction: ownership lost; the master re-arbitrates after reset, from master 0.

Decomposition:
- Shared constants/macros go in core/defines.v alongside INST_ADDR_BUS/INST_DATA_BUS:
  - slave-select field position;
  - slave index constants (ROM=0, RAM=1, UART=2, GPIO=3).
- One sub-module: rib_rr_arb. Parameter N; inputs req[N], ptr, en; output one-hot gnt and index. Pure combinational picker; pointer and grant registers stay in rib_xbar.

Test Plan:
- Reset, then m0 read of 0x1000_0004 with slave1 data 0xDEADBEEF → m_hold_o[0]=1 for 1 cycle; then s_rd_addr_o[1]=0x0000_0004 and m0 read data=0xDEADBEEF.
- m0 and m1 request in the same cycle after reset → m0 granted first; when m0 drops req, m1 is owned the next cycle with no idle cycle; m0 re-request waits behind m1.
- MAX_BURST=4: m0 holds req continuously while m2 requests → m0 owns exactly 4 cycles, m2 then owns; m0's hold rises on the handoff cycle.
- Owner writes 0x2000_0010 with data 0x55 and reads 0x3000_0000 in the same cycle → s_wr_en_o[2]=1 with data 0x55; s_rd_addr_o[3]=0; other slaves all zero.
- N_SLAVES=4, write to 0x7000_0000 → no s_wr_en_o asserted; err_o pulses 1 cycle; err_addr_o=0x7000_0000.
- rst_n low for 1 cycle while m1 owns → own_vld=0 and outputs zero; m1 with req still high is re-granted 1 cycle after release.

Source files
------------

// File: rtl/rib_xbar_pkg.sv
// Shared constants for the RIB crossbar: default slave-select field position,
// slave index map and ownership state encoding.
package rib_xbar_pkg;

    // Default slave-select field: addr[31:28]
    localparam int unsigned SEL_HI_DEF = 31;
    localparam int unsigned SEL_W_DEF  = 4;

    // Slave index map of the base system
    localparam int unsigned SLV_ROM  = 0;
    localparam int unsigned SLV_RAM  = 1;
    localparam int unsigned SLV_UART = 2;
    localparam int unsigned SLV_GPIO = 3;

    // Bus ownership states
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_OWNED = 1'b1;

    // Width of an index into n items, never less than one bit
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rib_rr_arb.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
module rib_rr_arb
    import rib_xbar_pkg::*;
#(
    parameter int unsigned N  = 3,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          vld
);

    int unsigned    cand;
    logic [IW-1:0]  cand_idx;

    // Scan ptr+1 .. ptr+N (mod N); the first asserted request wins
    always_comb begin
        gnt      = '0;
        idx      = '0;
        vld      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        if (en) begin
            for (int unsigned k = 1; k <= N; k++) begin
                cand     = (32'(ptr) + k) % N;
                cand_idx = IW'(cand);
                if (!vld && req[cand_idx]) begin
                    vld           = 1'b1;
                    gnt[cand_idx] = 1'b1;
                    idx           = cand_idx;
                end
            end
        end
    end

endmodule

// File: rtl/rib_xbar.sv
// N-master / N-slave RIB crossbar with registered round-robin ownership,
// burst limiting and unmapped-access error capture.
module rib_xbar
    import rib_xbar_pkg::*;
#(
    parameter int unsigned N_MASTERS = 3,
    parameter int unsigned N_SLAVES  = 4,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned SEL_HI    = SEL_HI_DEF,
    parameter int unsigned SEL_W     = SEL_W_DEF,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_MASTERS-1:0]    m_wr_req_i,
    input  logic [N_MASTERS-1:0]    m_wr_en_i,
    input  logic [N_MASTERS*AW-1:0] m_wr_addr_i,
    input  logic [N_MASTERS*DW-1:0] m_wr_data_i,
    input  logic [N_MASTERS-1:0]    m_rd_req_i,
    input  logic [N_MASTERS*AW-1:0] m_rd_addr_i,
    output logic [N_MASTERS*DW-1:0] m_rd_data_o,
    output logic [N_MASTERS-1:0]    m_hold_o,
    output logic [N_SLAVES-1:0]     s_wr_en_o,
    output logic [N_SLAVES*AW-1:0]  s_wr_addr_o,
    output logic [N_SLAVES*DW-1:0]  s_wr_data_o,
    output logic [N_SLAVES*AW-1:0]  s_rd_addr_o,
    input  logic [N_SLAVES*DW-1:0]  s_rd_data_i,
    output logic                    err_o,
    output logic [AW-1:0]           err_addr_o
);

    localparam int unsigned MW = idx_w(N_MASTERS);
    localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    // With no limit the counter just parks at all-ones and is never consulted
    localparam logic [BW-1:0] BURST_TOP = (MAX_BURST == 0) ? '1 : BW'(MAX_BURST - 1);
    localparam logic [AW-1:0] SEL_MASK  = AW'({SEL_W{1'b1}}) << (SEL_HI + 1 - SEL_W);

    logic                 own_q;
    logic [N_MASTERS-1:0] gnt_q;
    logic [MW-1:0]        rr_ptr_q;
    logic [BW-1:0]        burst_cnt_q;
    logic                 err_q;
    logic [AW-1:0]        err_addr_q;

    logic [N_MASTERS-1:0] req;
    logic                 own_vld, owner_req, others_req, burst_hit, arb_en;
    logic [N_MASTERS-1:0] arb_gnt;
    logic [MW-1:0]        arb_idx;
    logic                 arb_vld;

    logic [AW-1:0]        wr_addr_a [N_MASTERS];
    logic [DW-1:0]        wr_data_a [N_MASTERS];
    logic [AW-1:0]        rd_addr_a [N_MASTERS];
    logic                 wr_act, rd_act, wr_map, rd_map, wr_err, rd_err;
    logic [AW-1:0]        o_wr_addr, o_rd_addr;
    logic [SEL_W-1:0]     wr_sel, rd_sel;
    logic [DW-1:0]        rd_data_sel;

    assign req        = m_wr_req_i | m_rd_req_i;
    assign own_vld    = (own_q == ST_OWNED);
    assign owner_req  = |(req & gnt_q);
    assign others_req = |(req & ~gnt_q);
    assign burst_hit  = (MAX_BURST != 0) && (burst_cnt_q == BURST_TOP) && others_req;
    assign arb_en     = !own_vld || !owner_req || burst_hit;
    assign m_hold_o   = req & ~({N_MASTERS{own_vld}} & gnt_q);

    rib_rr_arb #(
        .N (N_MASTERS)
    ) u_arb (
        .req (req),
        .ptr (rr_ptr_q),
        .en  (arb_en),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .vld (arb_vld)
    );

    // Ownership, round-robin pointer and burst counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            own_q       <= ST_IDLE;
            gnt_q       <= '0;
            rr_ptr_q    <= MW'(N_MASTERS - 1);
            burst_cnt_q <= '0;
        end else if (arb_en) begin
            if (arb_vld) begin
                own_q       <= ST_OWNED;
                gnt_q       <= arb_gnt;
                rr_ptr_q    <= arb_idx;
                burst_cnt_q <= '0;
            end else begin
                own_q <= ST_IDLE;
                gnt_q <= '0;
            end
        end else if (burst_cnt_q != BURST_TOP) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
        end
    end

    // Unpack master buses so the owner can be selected by index
    always_comb begin
        for (int unsigned m = 0; m < N_MASTERS; m++) begin
            wr_addr_a[m] = m_wr_addr_i[m*AW +: AW];
            wr_data_a[m] = m_wr_data_i[m*DW +: DW];
            rd_addr_a[m] = m_rd_addr_i[m*AW +: AW];
        end
    end

    // rr_ptr_q always names the current owner while the bus is owned
    assign o_wr_addr = wr_addr_a[rr_ptr_q];
    assign o_rd_addr = rd_addr_a[rr_ptr_q];
    assign wr_sel    = o_wr_addr[SEL_HI -: SEL_W];
    assign rd_sel    = o_rd_addr[SEL_HI -: SEL_W];
    assign wr_act    = own_vld && m_wr_req_i[rr_ptr_q];
    assign rd_act    = own_vld && m_rd_req_i[rr_ptr_q];
    assign wr_map    = 32'(wr_sel) < N_SLAVES;
    assign rd_map    = 32'(rd_sel) < N_SLAVES;
    assign wr_err    = wr_act && !wr_map;
    assign rd_err    = rd_act && !rd_map;

    // Route owner channels to the decoded slaves; everything else reads as zero
    always_comb begin
        s_wr_en_o   = '0;
        s_wr_addr_o = '0;
        s_wr_data_o = '0;
        s_rd_addr_o = '0;
        m_rd_data_o = '0;
        rd_data_sel = '0;
        for (int unsigned s = 0; s < N_SLAVES; s++) begin
            if (wr_act && wr_sel == SEL_W'(s)) begin
                s_wr_en_o[s]          = m_wr_en_i[rr_ptr_q];
                s_wr_addr_o[s*AW +: AW] = o_wr_addr & ~SEL_MASK;
                s_wr_data_o[s*DW +: DW] = wr_data_a[rr_ptr_q];
            end
            if (rd_act && rd_sel == SEL_W'(s)) begin
                s_rd_addr_o[s*AW +: AW] = o_rd_addr & ~SEL_MASK;
                rd_data_sel             = s_rd_data_i[s*DW +: DW];
            end
        end
        for (int unsigned m = 0; m < N_MASTERS; m++) begin
            if (gnt_q[m]) m_rd_data_o[m*DW +: DW] = rd_data_sel;
        end
    end

    // Error pulse and capture of the latest unmapped address (write has priority)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_q <= wr_err || rd_err;
            if (wr_err) begin
                err_addr_q <= o_wr_addr;
            end else if (rd_err) begin
                err_addr_q <= o_rd_addr;
            end
        end
    end

    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_rib_xbar.sv
// Self-checking bench for rib_xbar: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_rib_xbar;

    localparam int NM = 3;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam logic [31:0] OFF = 32'h0FFF_FFFF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NM-1:0]     m_wr_req_i, m_wr_en_i, m_rd_req_i;
    logic [NM*AW-1:0]  m_wr_addr_i, m_rd_addr_i;
    logic [NM*DW-1:0]  m_wr_data_i;
    logic [NM*DW-1:0]  m_rd_data_o;
    logic [NM-1:0]     m_hold_o;
    logic [NS-1:0]     s_wr_en_o;
    logic [NS*AW-1:0]  s_wr_addr_o, s_rd_addr_o;
    logic [NS*DW-1:0]  s_wr_data_o, s_rd_data_i;
    logic              err_o;
    logic [AW-1:0]     err_addr_o;

    int passed = 0;
    int total  = 0;

    // Model state
    int          owner;
    int          ptr;
    int          run;
    logic        exp_err;
    logic [31:0] exp_err_addr;
    bit          model_ok = 0;

    always #5 clk = ~clk;

    rib_xbar #(
        .N_MASTERS (NM),
        .N_SLAVES  (NS),
        .AW        (AW),
        .DW        (DW),
        .SEL_HI    (31),
        .SEL_W     (4),
        .MAX_BURST (MB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_wr_req_i  (m_wr_req_i),
        .m_wr_en_i   (m_wr_en_i),
        .m_wr_addr_i (m_wr_addr_i),
        .m_wr_data_i (m_wr_data_i),
        .m_rd_req_i  (m_rd_req_i),
        .m_rd_addr_i (m_rd_addr_i),
        .m_rd_data_o (m_rd_data_o),
        .m_hold_o    (m_hold_o),
        .s_wr_en_o   (s_wr_en_o),
        .s_wr_addr_o (s_wr_addr_o),
        .s_wr_data_o (s_wr_data_o),
        .s_rd_addr_o (s_rd_addr_o),
        .s_rd_data_i (s_rd_data_i),
        .err_o       (err_o),
        .err_addr_o  (err_addr_o)
    );

    function automatic void chk(input string name, input logic [255:0] got,
                                input logic [255:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        else passed++;
    endfunction

    function automatic logic [31:0] wa(input int i); return m_wr_addr_i[i*AW +: AW]; endfunction
    function automatic logic [31:0] wd(input int i); return m_wr_data_i[i*DW +: DW]; endfunction
    function automatic logic [31:0] ra(input int i); return m_rd_addr_i[i*AW +: AW]; endfunction
    function automatic bit mreq(input int i); return m_wr_req_i[i] | m_rd_req_i[i]; endfunction

    // Model: advance ownership and error capture at each clock edge
    always @(posedge clk) begin
        bit werr, rerr, others;
        int nxt, j;
        if (!rst_n) begin
            owner = -1; ptr = NM - 1; run = 0;
            exp_err = 1'b0; exp_err_addr = '0;
            model_ok = 1;
        end else if (model_ok) begin
            werr = 0; rerr = 0; others = 0;
            if (owner >= 0) begin
                werr = m_wr_req_i[owner] && ((wa(owner) >> 28) >= NS);
                rerr = m_rd_req_i[owner] && ((ra(owner) >> 28) >= NS);
            end
            exp_err = werr | rerr;
            if (werr) exp_err_addr = wa(owner);
            else if (rerr) exp_err_addr = ra(owner);
            for (int k = 0; k < NM; k++) if (k != owner && mreq(k)) others = 1;
            // run = owned cycles so far including this one
            if (owner < 0 || !mreq(owner) || (run >= MB && others)) begin
                nxt = -1;
                for (int k = 1; k <= NM; k++) begin
                    j = (ptr + k) % NM;
                    if (nxt < 0 && mreq(j)) nxt = j;
                end
                if (nxt >= 0) begin owner = nxt; ptr = nxt; run = 1; end
                else owner = -1;
            end else begin
                run++;
            end
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin
        logic [NM-1:0]    e_hold;
        logic [NS-1:0]    e_wen;
        logic [NS*AW-1:0] e_waddr, e_wdata, e_raddr;
        logic [NM*DW-1:0] e_rdata;
        int s;
        if (model_ok) begin
            e_wen = '0; e_waddr = '0; e_wdata = '0; e_raddr = '0; e_rdata = '0;
            for (int i = 0; i < NM; i++) e_hold[i] = mreq(i) && (owner != i);
            if (owner >= 0) begin
                if (m_wr_req_i[owner]) begin
                    s = int'(wa(owner) >> 28);
                    if (s < NS) begin
                        e_wen[s] = m_wr_en_i[owner];
                        e_waddr[s*AW +: AW] = wa(owner) & OFF;
                        e_wdata[s*DW +: DW] = wd(owner);
                    end
                end
                if (m_rd_req_i[owner]) begin
                    s = int'(ra(owner) >> 28);
                    if (s < NS) begin
                        e_raddr[s*AW +: AW] = ra(owner) & OFF;
                        e_rdata[owner*DW +: DW] = s_rd_data_i[s*DW +: DW];
                    end
                end
            end
            chk("hold", m_hold_o, e_hold);
            chk("s_wr_en", s_wr_en_o, e_wen);
            chk("s_wr_addr", s_wr_addr_o, e_waddr);
            chk("s_wr_data", s_wr_data_o, e_wdata);
            chk("s_rd_addr", s_rd_addr_o, e_raddr);
            chk("m_rd_data", m_rd_data_o, e_rdata);
            chk("err", err_o, exp_err);
            chk("err_addr", err_addr_o, exp_err_addr);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_wr_req_i = '0; m_wr_en_i = '0; m_rd_req_i = '0;
        m_wr_addr_i = '0; m_rd_addr_i = '0; m_wr_data_i = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NM-1:0] sticky_wr, sticky_rd;
        clear_inputs();
        s_rd_data_i = '0;
        cyc();
        cyc();
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_hold", m_hold_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_err_addr", err_addr_o, 0);
        chk("rst_s_wr_en", s_wr_en_o, 0);

        // Single read from an idle bus: one cycle of hold, then routed
        cyc();
        m_rd_req_i[0] = 1'b1;
        m_rd_addr_i[0 +: AW] = 32'h1000_0004;
        s_rd_data_i[1*DW +: DW] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_hold_first", m_hold_o, 3'b001);
        cyc();
        @(negedge clk);
        chk("t1_hold_after", m_hold_o, 3'b000);
        chk("t1_rd_addr1", s_rd_addr_o[1*AW +: AW], 32'h0000_0004);
        chk("t1_rd_data", m_rd_data_o[0 +: DW], 32'hDEAD_BEEF);
        cyc();
        clear_inputs();
        cyc();

        // Simultaneous m0/m1 after reset: m0 first, zero-bubble handoff to m1
        do_reset();
        m_rd_req_i = 3'b011;
        @(negedge clk);
        chk("t2_hold_both", m_hold_o, 3'b011);
        cyc();
        @(negedge clk);
        chk("t2_m0_owns", m_hold_o, 3'b010);
        cyc();
        m_rd_req_i = 3'b010;
        @(negedge clk);
        chk("t2_m0_drop", m_hold_o, 3'b010);
        cyc();
        m_rd_req_i = 3'b011;
        @(negedge clk);
        chk("t2_m1_owns", m_hold_o, 3'b001);
        cyc();
        @(negedge clk);
        chk("t2_m0_waits", m_hold_o, 3'b001);
        cyc();
        clear_inputs();
        cyc();
        cyc();

        // Burst limit: m0 owns exactly MB cycles while m2 waits
        m_rd_req_i = 3'b001;
        @(negedge clk);
        chk("t3_hold_idle", m_hold_o, 3'b001);
        cyc();
        m_rd_req_i = 3'b101;
        for (int k = 0; k < MB; k++) begin
            @(negedge clk);
            chk("t3_m0_burst", m_hold_o, 3'b100);
            cyc();
        end
        @(negedge clk);
        chk("t3_handoff", m_hold_o, 3'b001);
        cyc();
        clear_inputs();
        cyc();
        cyc();

        // Concurrent write to slave 2 and read from slave 3 by m1
        m_wr_req_i = 3'b010; m_wr_en_i = 3'b010; m_rd_req_i = 3'b010;
        m_wr_addr_i[1*AW +: AW] = 32'h2000_0010;
        m_wr_data_i[1*DW +: DW] = 32'h0000_0055;
        m_rd_addr_i[1*AW +: AW] = 32'h3000_0000;
        s_rd_data_i = {32'hCAFE_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        cyc();
        @(negedge clk);
        chk("t4_wr_en", s_wr_en_o, 4'b0100);
        chk("t4_wr_data", s_wr_data_o, 128'h55 << 64);
        chk("t4_wr_addr", s_wr_addr_o, 128'h10 << 64);
        chk("t4_rd_addr", s_rd_addr_o, 0);
        chk("t4_rd_data", m_rd_data_o, 96'hCAFE_0003 << 32);

        // Unmapped write
        cyc();
        m_rd_req_i = '0;
        m_wr_addr_i[1*AW +: AW] = 32'h7000_0000;
        @(negedge clk);
        chk("t5_no_wr_en", s_wr_en_o, 0);
        chk("t5_err_pre", err_o, 0);
        cyc();
        m_wr_req_i = '0; m_wr_en_i = '0;
        m_rd_req_i = 3'b010; m_rd_addr_i = '0;
        @(negedge clk);
        chk("t5_err_pulse", err_o, 1);
        chk("t5_err_addr", err_addr_o, 32'h7000_0000);
        cyc();
        @(negedge clk);
        chk("t5_err_clear", err_o, 0);
        chk("t5_err_addr_kept", err_addr_o, 32'h7000_0000);

        // Reset while m1 owns
        cyc();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_owned_pre", m_hold_o, 3'b000);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_hold_after_rst", m_hold_o, 3'b010);
        chk("t6_rd_addr_zero", s_rd_addr_o, 0);
        chk("t6_rd_data_zero", m_rd_data_o, 0);
        chk("t6_err_addr_zero", err_addr_o, 0);
        cyc();
        @(negedge clk);
        chk("t6_regrant", m_hold_o, 3'b000);
        cyc();

        // Randomized traffic with sticky requests and occasional reset
        sticky_wr = '0; sticky_rd = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NM; i++) begin
                if ($urandom_range(0, 5) == 0) sticky_wr[i] = ~sticky_wr[i];
                if ($urandom_range(0, 5) == 0) sticky_rd[i] = ~sticky_rd[i];
                m_wr_en_i[i] = 1'($urandom_range(0, 1));
                m_wr_addr_i[i*AW +: AW] = {4'($urandom_range(0, 5)), 28'($urandom)};
                m_rd_addr_i[i*AW +: AW] = {4'($urandom_range(0, 5)), 28'($urandom)};
                m_wr_data_i[i*DW +: DW] = $urandom;
            end
            for (int s = 0; s < NS; s++) s_rd_data_i[s*DW +: DW] = $urandom;
            m_wr_req_i = sticky_wr;
            m_rd_req_i = sticky_rd;
            rst_n = ($urandom_range(0, 199) != 0);
            cyc();
        end
        rst_n = 1'b1;
        clear_inputs();
        cyc();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
